// File: rtl/tdm_demux_1_to_8.sv
// 1:8 time-division demultiplexer: collects eight W-bit slots from a serial lane
// and presents the completed frame in parallel, with SOF-based framing and error pulses.
module tdm_demux_1_to_8 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   D,
  input  logic           D_valid,
  input  logic           SOF,
  output logic [8*W-1:0] Y,
  output logic           Y_valid,
  output logic [2:0]     S,
  output logic           busy,
  output logic           err
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_s;
  logic [2:0]     w_s_nxt;
  logic [8*W-1:0] r_y;
  logic           r_y_valid;
  logic           r_err;
  logic [W-1:0]   r_shadow [0:6];
  logic [8*W-1:0] w_frame;
  logic           w_commit;
  logic           w_err;
  logic           w_wr;
  logic [2:0]     w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_s       <= 3'd0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_err     <= 1'b0;
      for (int k = 0; k < 7; k++) r_shadow[k] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_s       <= w_s_nxt;
      r_y_valid <= w_commit;
      r_err     <= w_err;
      if (w_commit) r_y <= w_frame;
      if (w_wr) r_shadow[w_idx] <= D;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_wr        = 1'b0;
    w_idx       = r_s;
    unique case (r_state)
      IDLE: begin
        if (D_valid) begin
          if (SOF) begin
            w_wr        = 1'b1;
            w_idx       = 3'd0;
            w_s_nxt     = 3'd1;
            w_state_nxt = COLLECT;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (D_valid) begin
          if (SOF) begin
            // abort: restart at slot 0, stale slots get overwritten
            w_err   = 1'b1;
            w_wr    = 1'b1;
            w_idx   = 3'd0;
            w_s_nxt = 3'd1;
          end else if (r_s == 3'd7) begin
            w_commit    = 1'b1;
            w_s_nxt     = 3'd0;
            w_state_nxt = IDLE;
          end else begin
            w_wr    = 1'b1;
            w_s_nxt = 3'(r_s + 3'd1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // slot 7 comes straight from the lane on the committing beat
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < 7; k++) w_frame[k*W +: W] = r_shadow[k];
    w_frame[7*W +: W] = D;
  end

  always_comb begin
    busy    = (r_state == COLLECT);
    Y       = r_y;
    Y_valid = r_y_valid;
    S       = r_s;
    err     = r_err;
  end

endmodule

// File: tb/tb_tdm_demux_1_to_8.sv
// Directed testbench for tdm_demux_1_to_8, exercising a W=1 and a W=4 instance.
module tb_tdm_demux_1_to_8;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  d1;
  logic        v1, sof1;
  logic [7:0]  y1;
  logic        yv1, busy1, err1;
  logic [2:0]  s1;
  logic [3:0]  d4;
  logic        v4, sof4;
  logic [31:0] y4;
  logic        yv4, busy4, err4;
  logic [2:0]  s4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdm_demux_1_to_8 #(.W(1)) u1 (
    .clk(clk), .rst(rst), .D(d1), .D_valid(v1), .SOF(sof1),
    .Y(y1), .Y_valid(yv1), .S(s1), .busy(busy1), .err(err1)
  );

  tdm_demux_1_to_8 #(.W(4)) u4 (
    .clk(clk), .rst(rst), .D(d4), .D_valid(v4), .SOF(sof4),
    .Y(y4), .Y_valid(yv4), .S(s4), .busy(busy4), .err(err4)
  );

  task automatic drive1(input logic d, input logic v, input logic sof);
    d1 = d; v1 = v; sof1 = sof;
    d4 = 4'h0; v4 = 1'b0; sof4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drive4(input logic [3:0] d, input logic v, input logic sof);
    d4 = d; v4 = v; sof4 = sof;
    d1 = 1'b0; v1 = 1'b0; sof1 = 1'b0;
    @(posedge clk); #1;
  endtask

  // {Y_valid, S, busy, err}
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d1 = 1'($urandom); v1 = 1'($urandom); sof1 = 1'($urandom);
      d4 = 4'($urandom); v4 = 1'($urandom); sof4 = 1'($urandom);
      @(posedge clk); #1;
    end
    total++;
    if ({y1, yv1, s1, busy1, err1} !== 14'd0) begin
      bad++;
      $display("FAIL reset_w1 got=%h/%b%h%b%b exp=0", y1, yv1, s1, busy1, err1);
    end
    total++;
    if ({y4, yv4, s4, busy4, err4} !== 38'd0) begin
      bad++;
      $display("FAIL reset_w4 got=%h/%b%h%b%b exp=0", y4, yv4, s4, busy4, err4);
    end
    rst = 1'b0;
    drive1(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_frame();
    logic [7:0] f;
    f = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      drive1(f[i], 1'b1, i == 0);
      if (i < 7) begin
        total++;
        if ({yv1, s1, busy1} !== {1'b0, 3'(i + 1), 1'b1}) begin
          bad++;
          $display("FAIL frame_beat%0d got yv=%b s=%0d busy=%b exp yv=0 s=%0d busy=1",
                   i, yv1, s1, busy1, i + 1);
        end
      end
    end
    total++;
    if ({y1, yv1, s1, busy1, err1} !== {8'h4D, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL frame_commit got y=%h yv=%b s=%0d busy=%b err=%b exp y=4d yv=1 s=0 busy=0 err=0",
               y1, yv1, s1, busy1, err1);
    end
    drive1(1'b1, 1'b0, 1'b1);
    total++;
    if ({y1, yv1, s1, busy1} !== {8'h4D, 1'b0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL frame_pulse got y=%h yv=%b s=%0d busy=%b exp y=4d yv=0 s=0 busy=0",
               y1, yv1, s1, busy1);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] f;
    int gaps;
    for (int i = 0; i < 8; i++) drive1(1'b0, 1'b1, i == 0);
    total++;
    if ({y1, yv1} !== {8'h00, 1'b1}) begin
      bad++;
      $display("FAIL gap_zero got y=%h yv=%b exp y=00 yv=1", y1, yv1);
    end
    f = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      drive1(f[i], 1'b1, i == 0);
      if (i < 7) begin
        gaps = int'($urandom_range(3, 0));
        for (int g = 0; g < gaps; g++) begin
          drive1(1'($urandom), 1'b0, 1'($urandom));
          total++;
          if ({yv1, s1, busy1, err1} !== {1'b0, 3'(i + 1), 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL gap_hold got yv=%b s=%0d busy=%b err=%b exp yv=0 s=%0d busy=1 err=0",
                     yv1, s1, busy1, err1, i + 1);
          end
        end
      end
    end
    total++;
    if ({y1, yv1, s1, busy1} !== {8'h4D, 1'b1, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL gap_commit got y=%h yv=%b s=%0d busy=%b exp y=4d yv=1 s=0 busy=0",
               y1, yv1, s1, busy1);
    end
    drive1(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    logic [31:0] a;
    a = 32'h89AB_CDEF;
    for (int i = 0; i < 8; i++) drive4(a[i*4 +: 4], 1'b1, i == 0);
    total++;
    if ({y4, yv4} !== {a, 1'b1}) begin
      bad++;
      $display("FAIL abort_a got y=%h yv=%b exp y=%h yv=1", y4, yv4, a);
    end
    drive4(4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive4(4'h9, 1'b1, 1'b0);
    total++;
    if ({s4, busy4, err4} !== {3'd5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL abort_pre got s=%0d busy=%b err=%b exp s=5 busy=1 err=0", s4, busy4, err4);
    end
    drive4(4'h3, 1'b1, 1'b1);
    total++;
    if ({y4, yv4, s4, busy4, err4} !== {a, 1'b0, 3'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL abort_err got y=%h yv=%b s=%0d busy=%b err=%b exp y=%h yv=0 s=1 busy=1 err=1",
               y4, yv4, s4, busy4, err4, a);
    end
    for (int i = 1; i < 8; i++) begin
      drive4(4'(i), 1'b1, 1'b0);
      if (i == 1) begin
        total++;
        if ({err4, s4} !== {1'b0, 3'd2}) begin
          bad++;
          $display("FAIL abort_errpulse got err=%b s=%0d exp err=0 s=2", err4, s4);
        end
      end
    end
    total++;
    if ({y4, yv4, err4} !== {32'h7654_3213, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL abort_commit got y=%h yv=%b err=%b exp y=76543213 yv=1 err=0", y4, yv4, err4);
    end
    drive4(4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_err();
    drive1(1'b1, 1'b1, 1'b0);
    total++;
    if ({yv1, s1, busy1, err1} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL idle_err got yv=%b s=%0d busy=%b err=%b exp yv=0 s=0 busy=0 err=1",
               yv1, s1, busy1, err1);
    end
    drive1(1'b1, 1'b0, 1'b1);
    total++;
    if ({y1, yv1, s1, busy1, err1} !== {8'h4D, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL idle_sof_novalid got y=%h yv=%b s=%0d busy=%b err=%b exp y=4d yv=0 s=0 busy=0 err=0",
               y1, yv1, s1, busy1, err1);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f;
    f = 16'h3C_A5;
    for (int i = 0; i < 16; i++) begin
      drive1(f[i], 1'b1, (i % 8) == 0);
      total++;
      if (yv1 !== ((i % 8) == 7)) begin
        bad++;
        $display("FAIL b2b_pulse beat%0d got yv=%b exp yv=%b", i, yv1, (i % 8) == 7);
      end
      if (i == 7 || i == 15) begin
        total++;
        if ({y1, busy1} !== {(i == 7) ? 8'hA5 : 8'h3C, 1'b0}) begin
          bad++;
          $display("FAIL b2b_y beat%0d got y=%h busy=%b exp y=%h busy=0",
                   i, y1, busy1, (i == 7) ? 8'hA5 : 8'h3C);
        end
      end
    end
    for (int i = 0; i < 4; i++) drive1(1'b1, 1'b1, i == 0);
    total++;
    if ({s1, busy1} !== {3'd4, 1'b1}) begin
      bad++;
      $display("FAIL b2b_mid got s=%0d busy=%b exp s=4 busy=1", s1, busy1);
    end
    rst = 1'b1;
    drive1(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    total++;
    if ({y1, yv1, s1, busy1, err1} !== 14'd0) begin
      bad++;
      $display("FAIL b2b_rst got y=%h yv=%b s=%0d busy=%b err=%b exp all 0",
               y1, yv1, s1, busy1, err1);
    end
    for (int i = 0; i < 4; i++) begin
      drive1(1'b0, 1'b0, 1'b0);
      total++;
      if ({yv1, busy1, s1} !== {1'b0, 1'b0, 3'd0}) begin
        bad++;
        $display("FAIL b2b_after_rst got yv=%b busy=%b s=%0d exp 0", yv1, busy1, s1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    d1 = 1'b0; v1 = 1'b0; sof1 = 1'b0;
    d4 = 4'h0; v4 = 1'b0; sof4 = 1'b0;
    test_reset();
    test_frame();
    test_gaps();
    test_abort();
    test_idle_err();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
